// File: rtl/pc_fetch_ctl_pkg.sv
// Shared constants, encodings and FSM state type for the PC fetch controller.
package pc_fetch_ctl_pkg;

    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    localparam logic [1:0] FUNC_SEQ    = 2'b00;
    localparam logic [1:0] FUNC_BRANCH = 2'b01;
    localparam logic [1:0] FUNC_JUMP   = 2'b10;
    localparam logic [1:0] FUNC_JR     = 2'b11;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } fetch_state_t;

    // Word offset of a branch: sign-extended immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctl_branch_cmp.sv
// Branch condition evaluation: decides taken/not-taken from opcode and GPR values.
module branch_cmp
    import pc_fetch_ctl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic        regimm_ge,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_data == 32'd0);
    assign rs_neg  = rs_data[31];

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:    taken = (rs_data == rt_data);
            OP_BNE:    taken = (rs_data != rt_data);
            OP_BLEZ:   taken = rs_neg || rs_zero;
            OP_BGTZ:   taken = !rs_neg && !rs_zero;
            // regimm_ge selects bgez, otherwise bltz.
            OP_REGIMM: taken = regimm_ge ? !rs_neg : rs_neg;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctl.sv
// Two-state fetch/execute PC controller: fetches at PC, then waits for one
// commit, exception or eret event to select the next PC.
module pc_fetch_ctl
    import pc_fetch_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PC_ctl_func,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        pc_update,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        if_ready,
    output logic        if_req,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic [31:0] exc_epc,
    output logic        exc_taken,
    output logic        branch_taken,
    output logic        pc_misaligned,
    output logic        state_dbg
);

    fetch_state_t state;

    logic        br_cond;
    logic        pc_event;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        next_trap;
    logic        next_misaligned;
    logic        next_branch;

    // Fetch handshake: if_req is the valid, if_ready the ready; the word is
    // accepted on any rising edge where both are high. if_req is forced low
    // while rst is asserted so no request escapes the reset cycle.
    assign if_req    = (state == ST_FETCH) && !rst;
    assign PC_plus4  = PC + 32'd4;
    assign state_dbg = state;

    branch_cmp u_branch_cmp (
        .opcode    (ins[31:26]),
        .regimm_ge (ins[16]),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .taken     (br_cond)
    );

    assign br_target   = PC_plus4 + branch_offset(ins[15:0]);
    assign jump_target = {PC_plus4[31:28], ins[25:0], 2'b00};
    assign pc_event    = exc_req || eret || pc_update;

    always_comb begin
        next_pc         = PC_plus4;
        next_trap       = 1'b0;
        next_misaligned = 1'b0;
        next_branch     = 1'b0;
        if (exc_req) begin
            next_pc   = EXC_VEC;
            next_trap = 1'b1;
        end else if (eret) begin
            next_pc = epc;
        end else begin
            case (PC_ctl_func)
                FUNC_BRANCH: begin
                    if (br_cond) begin
                        next_pc     = br_target;
                        next_branch = 1'b1;
                    end
                end
                FUNC_JUMP: next_pc = jump_target;
                FUNC_JR: begin
                    // A misaligned jr target traps instead of being fetched.
                    if (rs_data[1:0] != 2'b00) begin
                        next_pc         = EXC_VEC;
                        next_trap       = 1'b1;
                        next_misaligned = 1'b1;
                    end else begin
                        next_pc = rs_data;
                    end
                end
                default: next_pc = PC_plus4;
            endcase
        end
    end

    // Status pulses are registered: they are high in the cycle where PC and
    // exc_epc already show the result of the accepted event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FETCH;
            PC            <= RESET_VEC;
            exc_epc       <= 32'd0;
            exc_taken     <= 1'b0;
            branch_taken  <= 1'b0;
            pc_misaligned <= 1'b0;
        end else begin
            exc_taken     <= 1'b0;
            branch_taken  <= 1'b0;
            pc_misaligned <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (if_ready) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (pc_event) begin
                        state         <= ST_FETCH;
                        PC            <= next_pc;
                        exc_taken     <= next_trap;
                        branch_taken  <= next_branch;
                        pc_misaligned <= next_misaligned;
                        if (next_trap) begin
                            exc_epc <= PC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// Bench for pc_fetch_ctl: directed scenarios plus randomized events checked
// against a behavioural next-PC model.
module tb_pc_fetch_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PC_ctl_func;
    logic [31:0] ins, rs_data, rt_data, epc;
    logic        pc_update, exc_req, eret, if_ready;
    logic        if_req;
    logic [31:0] PC, PC_plus4, exc_epc;
    logic        exc_taken, branch_taken, pc_misaligned, state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_pc;
    logic [31:0] mdl_epc;
    logic        exp_exc, exp_br, exp_mis;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_fetch_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .PC_ctl_func   (PC_ctl_func),
        .ins           (ins),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .pc_update     (pc_update),
        .exc_req       (exc_req),
        .eret          (eret),
        .epc           (epc),
        .if_ready      (if_ready),
        .if_req        (if_req),
        .PC            (PC),
        .PC_plus4      (PC_plus4),
        .exc_epc       (exc_epc),
        .exc_taken     (exc_taken),
        .branch_taken  (branch_taken),
        .pc_misaligned (pc_misaligned),
        .state_dbg     (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_cond(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        int s;
        s = $signed(rs);
        case (i[31:26])
            6'd4:    return rs == rt;
            6'd5:    return rs != rt;
            6'd6:    return s <= 0;
            6'd7:    return s > 0;
            6'd1:    return i[16] ? (s >= 0) : (s < 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_event(input logic [1:0] f, input logic [31:0] i, input logic [31:0] rs,
                               input logic [31:0] rt, input logic ex, input logic er,
                               input logic up, input logic [31:0] ep);
        logic [31:0] seq, off;
        seq = mdl_pc + 32'd4;
        off = 32'($signed(i[15:0])) * 32'd4;
        exp_exc = 1'b0; exp_br = 1'b0; exp_mis = 1'b0;
        if (ex) begin
            mdl_epc = mdl_pc; mdl_pc = 32'h4180; exp_exc = 1'b1;
        end else if (er) begin
            mdl_pc = ep;
        end else if (up) begin
            if (f == 2'd0) mdl_pc = seq;
            else if (f == 2'd1) begin
                exp_br = ref_cond(i, rs, rt);
                mdl_pc = exp_br ? seq + off : seq;
            end else if (f == 2'd2) mdl_pc = (seq & 32'hF000_0000) | ((i & 32'h03FF_FFFF) * 4);
            else if (rs % 4 == 0) mdl_pc = rs;
            else begin
                mdl_epc = mdl_pc; mdl_pc = 32'h4180; exp_exc = 1'b1; exp_mis = 1'b1;
            end
        end
        exp_q.push_back(mdl_pc);
    endtask

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        PC_ctl_func = 2'd0; ins = 32'd0; rs_data = 32'd0; rt_data = 32'd0; epc = 32'd0;
        pc_update = 1'b0; exc_req = 1'b0; eret = 1'b0; if_ready = 1'b0;
    endtask

    task automatic do_fetch();
        @(negedge clk);
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready = 1'b0;
    endtask

    task automatic do_exec(input logic [1:0] f, input logic [31:0] i, input logic [31:0] rs,
                           input logic [31:0] rt, input logic ex, input logic er,
                           input logic up, input logic [31:0] ep);
        @(negedge clk);
        PC_ctl_func = f; ins = i; rs_data = rs; rt_data = rt;
        exc_req = ex; eret = er; pc_update = up; epc = ep;
        model_event(f, i, rs, rt, ex, er, up, ep);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (PC !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h3000); end
        checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL reset_if_req: got %b expected 0", if_req); end
        checks++; if (exc_epc !== 32'd0) begin errors++; $display("FAIL reset_epc: got %h expected 0", exc_epc); end
        checks++; if ({exc_taken, branch_taken, pc_misaligned} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {exc_taken, branch_taken, pc_misaligned}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (if_req !== 1'b1) begin errors++; $display("FAIL reset_if_req_rise: got %b expected 1", if_req); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (if_req !== 1'b1 || PC !== 32'h3000) begin
                errors++; $display("FAIL reset_hold: if_req %b pc %h expected 1 / %h", if_req, PC, 32'h3000); end
        end
        mdl_pc = 32'h3000; mdl_epc = 32'd0;
        exp_q.delete();
    endtask

    task automatic test_branch();
        do_fetch();
        checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL exec_if_req: got %b expected 0", if_req); end
        do_exec(2'b01, 32'h1000_FFFF, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3000 || branch_taken !== 1'b1) begin
            errors++; $display("FAIL beq_taken: pc %h bt %b expected %h / 1", PC, branch_taken, 32'h3000); end
        do_fetch();
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bt_one_cycle: got %b expected 0", branch_taken); end
        do_exec(2'b01, 32'h1400_FFFF, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3004 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL bne_not_taken: pc %h bt %b expected %h / 0", PC, branch_taken, 32'h3004); end
    endtask

    task automatic test_jump_jr();
        do_fetch();
        do_exec(2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3008) begin errors++; $display("FAIL seq_pc: got %h expected %h", PC, 32'h3008); end
        do_fetch();
        do_exec(2'b10, 32'h0800_0C04, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3010) begin errors++; $display("FAIL jump_pc: got %h expected %h", PC, 32'h3010); end
        do_fetch();
        do_exec(2'b11, 32'd0, 32'h3008, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3008) begin errors++; $display("FAIL jr_pc: got %h expected %h", PC, 32'h3008); end
        do_fetch();
        do_exec(2'b11, 32'd0, 32'h3003, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h4180 || exc_epc !== 32'h3008 || pc_misaligned !== 1'b1 || exc_taken !== 1'b1) begin
            errors++; $display("FAIL jr_misaligned: pc %h epc %h mis %b exc %b expected 4180/3008/1/1",
                               PC, exc_epc, pc_misaligned, exc_taken); end
    endtask

    task automatic test_priority();
        do_fetch();
        do_exec(2'b11, 32'd0, 32'h3020, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        do_fetch();
        do_exec(2'b00, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h3024);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h4180 || exc_epc !== 32'h3020 || exc_taken !== 1'b1) begin
            errors++; $display("FAIL prio_exc: pc %h epc %h exc %b expected 4180/3020/1", PC, exc_epc, exc_taken); end
        do_fetch();
        do_exec(2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h3024);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'h3024 || exc_taken !== 1'b0) begin
            errors++; $display("FAIL prio_eret: pc %h exc %b expected 3024/0", PC, exc_taken); end
    endtask

    task automatic test_wrap_fetch();
        do_fetch();
        do_exec(2'b11, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC_plus4 !== 32'd0) begin errors++; $display("FAIL plus4_wrap: got %h expected 0", PC_plus4); end
        do_fetch();
        do_exec(2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
        void'(exp_q.pop_front());
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL seq_wrap: got %h expected 0", PC); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exc_req = 1'b1; eret = 1'b1; pc_update = 1'b1; epc = 32'h1234_5678;
            @(posedge clk); #1;
            checks++; if (PC !== 32'd0 || if_req !== 1'b1 || exc_taken !== 1'b0 || exc_epc !== mdl_epc) begin
                errors++; $display("FAIL fetch_ignore: pc %h req %b exc %b epc %h expected 0/1/0/%h",
                                   PC, if_req, exc_taken, exc_epc, mdl_epc); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_fetch();
        @(negedge clk);
        rst = 1'b1; exc_req = 1'b1; pc_update = 1'b1;
        @(posedge clk); #1;
        checks++; if (PC !== 32'h3000 || exc_taken !== 1'b0 || exc_epc !== 32'd0 || if_req !== 1'b0) begin
            errors++; $display("FAIL reset_override: pc %h exc %b epc %h req %b expected 3000/0/0/0",
                               PC, exc_taken, exc_epc, if_req); end
        @(negedge clk);
        rst = 1'b0; clear_inputs();
        #1;
        checks++; if (if_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b expected 1", if_req); end
        mdl_pc = 32'h3000; mdl_epc = 32'd0;
    endtask

    task automatic test_random();
        logic [5:0]  ops[7];
        logic [31:0] vals[5];
        logic [31:0] i, rs, rt, got_exp;
        logic [1:0]  f;
        int kind;
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'h3F};
        vals = '{32'd0, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        for (int n = 0; n < 60; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                @(negedge clk);
                exc_req = 1'($urandom_range(0, 1)); eret = 1'($urandom_range(0, 1));
                pc_update = 1'($urandom_range(0, 1)); epc = $urandom;
                @(posedge clk); #1;
                checks++; if (PC !== mdl_pc || if_req !== 1'b1 || exc_taken !== 1'b0) begin
                    errors++; $display("FAIL rnd_fetch_wait: pc %h req %b exc %b expected %h/1/0",
                                       PC, if_req, exc_taken, mdl_pc); end
                clear_inputs();
            end
            do_fetch();
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                @(negedge clk);
                PC_ctl_func = 2'($urandom_range(0, 3)); rs_data = $urandom;
                @(posedge clk); #1;
                checks++; if (PC !== mdl_pc || {exc_taken, branch_taken, pc_misaligned} !== 3'b000) begin
                    errors++; $display("FAIL rnd_exec_hold: pc %h pulses %b expected %h/000",
                                       PC, {exc_taken, branch_taken, pc_misaligned}, mdl_pc); end
                clear_inputs();
            end
            i = {ops[$urandom_range(0, 6)], 26'($urandom)};
            rs = ($urandom_range(0, 1) == 1) ? vals[$urandom_range(0, 4)] : $urandom;
            rt = ($urandom_range(0, 1) == 1) ? rs : vals[$urandom_range(0, 4)];
            f = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            do_exec(f, i, rs, rt, kind == 0, kind == 1, 1'b1, {$urandom} & 32'hFFFF_FFFC);
            got_exp = exp_q.pop_front();
            checks++; if (PC !== got_exp || PC_plus4 !== got_exp + 32'd4) begin
                errors++; $display("FAIL rnd_pc: pc %h plus4 %h expected %h (func %0d ins %h rs %h rt %h kind %0d)",
                                   PC, PC_plus4, got_exp, f, i, rs, rt, kind); end
            checks++; if (exc_taken !== exp_exc || branch_taken !== exp_br || pc_misaligned !== exp_mis
                          || exc_epc !== mdl_epc) begin
                errors++; $display("FAIL rnd_status: exc %b br %b mis %b epc %h expected %b %b %b %h",
                                   exc_taken, branch_taken, pc_misaligned, exc_epc, exp_exc, exp_br, exp_mis, mdl_epc); end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        mdl_pc = 32'h3000; mdl_epc = 32'd0;
        test_reset();
        test_branch();
        test_jump_jr();
        test_priority();
        test_wrap_fetch();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctl.md
PC_FETCH_CTL -- requirements
Module: pc_fetch_ctl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port PC_ctl_func, input, 2: next-PC select (00 seq, 01 branch, 10 jump, 11 jr).
REQ-004 SHALL have port ins, input, 32: instruction currently executing.
REQ-005 SHALL have ports rs_data and rt_data, input, 32 each: GPR read values for branch compare and jr target.
REQ-006 SHALL have port pc_update, input, 1: commit strobe from main control; advance PC.
REQ-007 SHALL have port exc_req, input, 1: exception/interrupt entry request.
REQ-008 SHALL have port eret, input, 1: return-from-exception strobe.
REQ-009 SHALL have port epc, input, 32: CP0 EPC value used on eret.
REQ-010 SHALL have port if_ready, input, 1: instruction memory has the word for PC.
REQ-011 SHALL have port if_req, output, 1: fetch request for address PC.
REQ-012 SHALL have port PC, output, 32: current instruction address.
REQ-013 SHALL have port PC_plus4, output, 32: PC+4, the link value for jal/jalr.
REQ-014 SHALL have port exc_epc, output, 32: PC of instruction that trapped, valid with exc_taken.
REQ-015 SHALL have ports exc_taken, branch_taken and pc_misaligned, output, 1 each: single-cycle status pulses.

Function
REQ-016 SHALL implement FSM states FETCH and EXEC; reset state FETCH.
REQ-017 SHALL drive if_req=1 only in FETCH; FETCH->EXEC when if_ready=1, otherwise remain (no timeout).
REQ-018 SHALL ignore pc_update, exc_req and eret while in FETCH.
REQ-019 SHALL in EXEC hold PC until exactly one event; priority exc_req > eret > pc_update; on event load next PC and go FETCH the following cycle.
REQ-020 SHALL on exc_req load PC=0x0000_4180, set exc_epc=PC, pulse exc_taken.
REQ-021 SHALL on eret load PC=epc.
REQ-022 SHALL on pc_update with func 00 load PC+4 (mod 2^32; 0xFFFF_FFFC wraps to 0x0000_0000).
REQ-023 SHALL on func 01 evaluate ins[31:26]: 000100 beq (rs==rt), 000101 bne, 000110 blez (signed rs<=0), 000111 bgtz (rs>0), 000001 with ins[16]=0 bltz, ins[16]=1 bgez; unknown opcode = not taken.
REQ-024 SHALL on taken branch load PC+4 + (sign-extended ins[15:0] << 2), modulo 2^32, and pulse branch_taken; not taken loads PC+4.
REQ-025 SHALL on func 10 load {PC_plus4[31:28], ins[25:0], 2'b00}.
REQ-026 SHALL on func 11 load rs_data if rs_data[1:0]==00; otherwise load 0x0000_4180, set exc_epc=PC, pulse pc_misaligned and exc_taken.
REQ-027 SHALL drive PC_plus4 combinationally from PC; no delay slot.
REQ-028 SHALL assert status pulses for exactly the cycle the event is accepted, 0 otherwise.

Reset
REQ-029 SHALL on rst=1 set PC=0x0000_3000, state=FETCH, exc_epc=0, all pulses 0, if_req=0 during the reset cycle.
REQ-030 SHALL let rst override any in-flight fetch or simultaneous event; first request after reset is for 0x0000_3000.

Structure
REQ-031 SHALL place reset vector, exception vector, PC_ctl_func encodings, branch opcodes and FSM state encoding in a shared package.
REQ-032 SHALL isolate the REQ-023 condition logic in one combinational sub-module branch_cmp.

Verification
REQ-033 SHALL cover reset: rst 1 cycle -> PC=0x0000_3000, if_req rises next cycle, stays high through 3 cycles of if_ready=0.
REQ-034 SHALL cover branch: PC=0x3000, beq rs=rt=5, imm=0xFFFF -> PC=0x3000, branch_taken pulse; bne same operands -> PC=0x3004.
REQ-035 SHALL cover jump/jr: PC=0x3008, j target 0x0000C04 -> PC=0x0000_3010; jr rs=0x3003 -> PC=0x4180, pc_misaligned, exc_epc=0x3008.
REQ-036 SHALL cover priority: exc_req, eret, pc_update same cycle at PC=0x3020 -> PC=0x4180, exc_epc=0x3020; then eret epc=0x3024 -> PC=0x3024.
REQ-037 SHALL cover wrap: PC=0xFFFF_FFFC, func 00 commit -> PC=0x0000_0000; events asserted during FETCH -> PC unchanged.
